// File: rtl/pcie_x1_tx_sched.sv
// Store-and-forward TX scheduler for the PCIe x1 core VC0 transmit port.
// Buffers whole TLPs, gates each on header/data credits, then streams it without gaps.
module pcie_x1_tx_sched #(
    parameter int DBUF_AW    = 9,
    parameter int META_AW    = 2,
    parameter int RECHK_WAIT = 2
) (
    input  logic        sys_clk_125,
    input  logic        rst,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [15:0] src_data,
    input  logic        src_sop,
    input  logic        src_eop,
    input  logic [1:0]  src_type,
    input  logic        src_has_data,
    input  logic [9:0]  src_len,
    input  logic        src_err,
    input  logic        dl_up,
    input  logic        tx_rdy_vc0,
    input  logic [8:0]  tx_ca_ph_vc0,
    input  logic [8:0]  tx_ca_nph_vc0,
    input  logic [8:0]  tx_ca_cplh_vc0,
    input  logic [12:0] tx_ca_pd_vc0,
    input  logic [12:0] tx_ca_npd_vc0,
    input  logic [12:0] tx_ca_cpld_vc0,
    input  logic        tx_ca_p_recheck_vc0,
    input  logic        tx_ca_cpl_recheck_vc0,
    output logic        tx_req_vc0,
    output logic [15:0] tx_data_vc0,
    output logic        tx_st_vc0,
    output logic        tx_end_vc0,
    output logic        tx_nlfy_vc0,
    output logic [2:0]  pkt_cnt,
    output logic [7:0]  drop_cnt
);
    localparam int DEPTH  = 1 << DBUF_AW;
    localparam int MDEPTH = 1 << META_AW;
    localparam int PW     = DBUF_AW + 1;
    localparam int ME_W   = 14 + 2 * PW;
    localparam logic [7:0] WAIT_INIT = (RECHK_WAIT > 0) ? 8'(RECHK_WAIT - 1) : 8'd0;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_REQ, S_STREAM} state_t;

    function automatic logic credit_ok(input logic [8:0] hca, input logic [12:0] dca,
                                       input logic has_data, input logic [9:0] len);
        logic [8:0] need;
        need = (len == 10'd0) ? 9'd256 : 9'((11'(len) + 11'd3) >> 2);
        return (hca[8] | (hca != 9'd0)) & (!has_data | dca[12] | ({4'd0, need} <= dca));
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [META_AW:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [15:0]   mem [DEPTH];
    logic [ME_W-1:0] meta_mem [MDEPTH];

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, free_ptr_q, free_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   start_q, start_d, rd_ptr_q, rd_ptr_d, idx_q, idx_d;
    logic            open_q, open_d;
    logic [1:0]      sop_type_q, sop_type_d;
    logic            sop_hd_q, sop_hd_d;
    logic [9:0]      sop_len_q, sop_len_d;
    logic [META_AW:0] meta_wr_q, meta_wr_d, meta_rd_q, meta_rd_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d, drop_cnt_q, drop_cnt_d;

    logic            accept, push, pop, flush, data_full, meta_full;
    logic [PW-1:0]   base, push_start, push_wc;
    logic [ME_W-1:0] meta_wdata;
    logic [META_AW:0] pkt_cnt_w;
    logic [1:0]      head_type;
    logic            head_hd, head_err, head_ok, head_rechk;
    logic [9:0]      head_len;
    logic [PW-1:0]   head_start, head_wc;
    logic [8:0]      hca;
    logic [12:0]     dca;

    assign pkt_cnt_w = meta_wr_q - meta_rd_q;
    assign pkt_cnt   = 3'(pkt_cnt_w);
    assign drop_cnt  = drop_cnt_q;
    // Full when the pointers differ only in the extra wrap bit.
    assign data_full = (wr_ptr_q[PW-1] != free_ptr_q[PW-1]) &&
                       (wr_ptr_q[DBUF_AW-1:0] == free_ptr_q[DBUF_AW-1:0]);
    assign meta_full = (meta_wr_q[META_AW] != meta_rd_q[META_AW]) &&
                       (meta_wr_q[META_AW-1:0] == meta_rd_q[META_AW-1:0]);
    assign src_ready = !data_full && !(meta_full && !open_q);
    assign accept    = src_valid && src_ready;

    assign {head_type, head_hd, head_len, head_err, head_start, head_wc} =
        meta_mem[meta_rd_q[META_AW-1:0]];

    always_comb begin
        hca        = tx_ca_ph_vc0;
        dca        = tx_ca_pd_vc0;
        head_rechk = tx_ca_p_recheck_vc0;
        case (head_type)
            2'd1: begin
                hca = tx_ca_nph_vc0;
                dca = tx_ca_npd_vc0;
            end
            2'd2: begin
                hca        = tx_ca_cplh_vc0;
                dca        = tx_ca_cpld_vc0;
                head_rechk = tx_ca_cpl_recheck_vc0;
            end
            default: ;
        endcase
        head_ok = credit_ok(hca, dca, head_hd, head_len);
    end

    // Write side: a new sop always restarts at the open TLP's start, discarding any partial.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        start_d      = start_q;
        open_d       = open_q;
        sop_type_d   = sop_type_q;
        sop_hd_d     = sop_hd_q;
        sop_len_d    = sop_len_q;
        base         = open_q ? start_q : wr_ptr_q;
        push         = 1'b0;
        push_start   = start_q;
        push_wc      = '0;
        if (accept) begin
            if (src_sop) begin
                start_d    = base;
                wr_ptr_d   = base + PW'(1);
                open_d     = !src_eop;
                sop_type_d = src_type;
                sop_hd_d   = src_has_data;
                sop_len_d  = src_len;
                push       = src_eop;
                push_start = base;
                push_wc    = PW'(1);
            end else if (open_q) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                open_d   = !src_eop;
                push     = src_eop;
                push_wc  = wr_ptr_q + PW'(1) - start_q;
            end
        end
        commit_ptr_d = push ? wr_ptr_d : commit_ptr_q;
        meta_wr_d    = meta_wr_q + (META_AW+1)'(push);
        meta_wdata   = {sop_type_d, sop_hd_d, sop_len_d, src_err, push_start, push_wc};
    end

    always_ff @(posedge sys_clk_125) begin
        if (accept && (src_sop || open_q))
            mem[base[DBUF_AW-1:0] + (src_sop ? DBUF_AW'(0) : wr_ptr_q[DBUF_AW-1:0] - base[DBUF_AW-1:0])] <= src_data;
        if (push)
            meta_mem[meta_wr_q[META_AW-1:0]] <= meta_wdata;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        pop         = 1'b0;
        flush       = 1'b0;
        tx_req_vc0  = 1'b0;
        tx_data_vc0 = 16'd0;
        tx_st_vc0   = 1'b0;
        tx_end_vc0  = 1'b0;
        tx_nlfy_vc0 = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!dl_up) flush = 1'b1;
                else if (pkt_cnt_w != '0) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!dl_up) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (head_rechk) begin
                    state_d    = (RECHK_WAIT > 0) ? S_WAIT : S_CHECK;
                    wait_cnt_d = WAIT_INIT;
                end else if (head_ok) begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (!dl_up) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 8'd0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            S_REQ: begin
                tx_req_vc0 = 1'b1;
                if (!dl_up) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (tx_rdy_vc0) begin
                    state_d  = S_STREAM;
                    rd_ptr_d = head_start;
                    idx_d    = '0;
                end
            end
            S_STREAM: begin
                // Buffer is read combinationally so every cycle carries a word.
                tx_data_vc0 = mem[rd_ptr_q[DBUF_AW-1:0]];
                tx_st_vc0   = (idx_q == '0);
                tx_end_vc0  = (idx_q == head_wc - PW'(1));
                tx_nlfy_vc0 = tx_end_vc0 && head_err;
                rd_ptr_d    = rd_ptr_q + PW'(1);
                idx_d       = idx_q + PW'(1);
                if (tx_end_vc0) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        meta_rd_d  = meta_rd_q;
        free_ptr_d = free_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (pop) begin
            meta_rd_d  = meta_rd_q + (META_AW+1)'(1);
            free_ptr_d = free_ptr_q + head_wc;
        end else if (flush) begin
            meta_rd_d  = meta_wr_q;
            free_ptr_d = commit_ptr_q;
            drop_cnt_d = sat_add(drop_cnt_q, pkt_cnt_w);
        end
    end

    always_ff @(posedge sys_clk_125) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            free_ptr_q   <= '0;
            commit_ptr_q <= '0;
            start_q      <= '0;
            rd_ptr_q     <= '0;
            idx_q        <= '0;
            open_q       <= 1'b0;
            meta_wr_q    <= '0;
            meta_rd_q    <= '0;
            wait_cnt_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            free_ptr_q   <= free_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            start_q      <= start_d;
            rd_ptr_q     <= rd_ptr_d;
            idx_q        <= idx_d;
            open_q       <= open_d;
            meta_wr_q    <= meta_wr_d;
            meta_rd_q    <= meta_rd_d;
            wait_cnt_q   <= wait_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
        sop_type_q <= sop_type_d;
        sop_hd_q   <= sop_hd_d;
        sop_len_q  <= sop_len_d;
    end
endmodule
